// File: rtl/tx_framer.sv
// rtl/tx_framer.sv - wraps payload bytes in a sync/sequence header and optional XOR trailer
// Optional trailer byte is built when TX_FRAMER_CHECKSUM_EN is defined.
module tx_framer #(
  parameter int                 width_p       = 8,
  parameter int                 frame_bytes_p = 9600,
  parameter logic [width_p-1:0] sync0_p       = 8'hA5,
  parameter logic [width_p-1:0] sync1_p       = 8'h5A
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [width_p-1:0] data_o,
  output logic [7:0]         seq_o,
  output logic               frame_done_o
);

  localparam int cnt_w_lp = (frame_bytes_p > 1) ? $clog2(frame_bytes_p) : 1;
  localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(frame_bytes_p - 1);

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    SEQ,
    PAYLOAD
`ifdef TX_FRAMER_CHECKSUM_EN
    , CSUM
`endif
  } state_e;

  state_e              state_r, state_n;
  logic [cnt_w_lp-1:0] cnt_r;
  logic                pay_hs;
  logic                frame_end;

`ifdef TX_FRAMER_CHECKSUM_EN
  logic [width_p-1:0]  csum_r;
`endif

  always_comb begin
    state_n   = state_r;
    valid_o   = 1'b0;
    ready_o   = 1'b0;
    data_o    = '0;
    pay_hs    = 1'b0;
    frame_end = 1'b0;
    unique case (state_r)
      IDLE: begin
        // Only start a header once upstream has a byte ready; the byte waits.
        if (valid_i) state_n = HDR0;
      end
      HDR0: begin
        valid_o = 1'b1;
        data_o  = sync0_p;
        if (ready_i) state_n = HDR1;
      end
      HDR1: begin
        valid_o = 1'b1;
        data_o  = sync1_p;
        if (ready_i) state_n = SEQ;
      end
      SEQ: begin
        valid_o = 1'b1;
        data_o  = width_p'(seq_o);
        if (ready_i) state_n = PAYLOAD;
      end
      PAYLOAD: begin
        valid_o = valid_i;
        ready_o = ready_i;
        data_o  = data_i;
        if (valid_i && ready_i) begin
          pay_hs = 1'b1;
          if (cnt_r == last_cnt_lp) begin
`ifdef TX_FRAMER_CHECKSUM_EN
            state_n = CSUM;
`else
            state_n   = IDLE;
            frame_end = 1'b1;
`endif
          end
        end
      end
`ifdef TX_FRAMER_CHECKSUM_EN
      CSUM: begin
        valid_o = 1'b1;
        data_o  = csum_r;
        if (ready_i) begin
          state_n   = IDLE;
          frame_end = 1'b1;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      seq_o        <= 8'h00;
      frame_done_o <= 1'b0;
    end else begin
      state_r      <= state_n;
      frame_done_o <= frame_end;
      if (frame_end) seq_o <= seq_o + 8'h01;
      if (state_r == IDLE) begin
        cnt_r <= '0;
      end else if (pay_hs) begin
        cnt_r <= (cnt_r == last_cnt_lp) ? '0 : cnt_r + cnt_w_lp'(1);
      end
    end
  end

`ifdef TX_FRAMER_CHECKSUM_EN
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      csum_r <= '0;
    end else if (state_r == IDLE) begin
      csum_r <= '0;
    end else if (pay_hs) begin
      csum_r <= csum_r ^ data_i;
    end
  end
`endif

endmodule

// File: tb/tb_tx_framer.sv
// tb/tb_tx_framer.sv - directed vector and stream checks for tx_framer (frame_bytes_p = 4)
module tb_tx_framer;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] data_i;
  logic       valid_o;
  logic       ready_i;
  logic [7:0] data_o;
  logic [7:0] seq_o;
  logic       frame_done_o;

  always #5 clk_i = ~clk_i;

  tx_framer #(
    .width_p      (8),
    .frame_bytes_p(4),
    .sync0_p      (8'hA5),
    .sync1_p      (8'h5A)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .data_i      (data_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .data_o      (data_o),
    .seq_o       (seq_o),
    .frame_done_o(frame_done_o)
  );

`ifdef TX_FRAMER_CHECKSUM_EN
  localparam int flen = 8;
  localparam int n_rows = 11;
`else
  localparam int flen = 7;
  localparam int n_rows = 10;
`endif

  typedef struct packed {
    logic       vi;
    logic       ri;
    logic [7:0] di;
    logic       evo;
    logic       ero;
    logic [7:0] edo;
    logic       edone;
    logic [7:0] eseq;
  } vec_t;

  vec_t       tbl [n_rows];
  int         vecs = 0;
  int         miscmp = 0;
  int         done_cnt;
  logic [7:0] in_q[$];
  logic [7:0] out_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp_seq;
  logic       prev_hold;
  logic [7:0] prev_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    data_i  = 8'h00;
    in_q.delete();
    prev_hold = 1'b0;
    #2;
    check("rst_valid_o", valid_o, 0);
    check("rst_ready_o", ready_o, 0);
    check("rst_data_o", data_o, 0);
    check("rst_seq_o", seq_o, 0);
    check("rst_done", frame_done_o, 0);
    @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b1;
    exp_seq = 8'h00;
  endtask

  // One cycle of an AXIS-correct upstream source and a capturing sink, starting at a negedge.
  task automatic step(input bit rdy_rand, input bit gap_rand);
    bit acc;
    ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (!valid_i && in_q.size() > 0)
      valid_i = gap_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    data_i = valid_i ? in_q[0] : 8'h00;
    #2;
    if (prev_hold) begin
      check("hold_valid", valid_o, 1);
      check("hold_data", data_o, prev_data);
    end
    if (valid_o && ready_i) out_q.push_back(data_o);
    if (frame_done_o) done_cnt++;
    prev_hold = valid_o && !ready_i;
    prev_data = data_o;
    acc = valid_i && ready_o;
    @(posedge clk_i);
    @(negedge clk_i);
    if (acc) begin
      void'(in_q.pop_front());
      valid_i = 1'b0;
    end
  endtask

  task automatic run(input int n_out, input bit rr, input bit gr, input string name);
    int budget = 20000;
    while (out_q.size() < n_out && budget > 0) begin
      step(rr, gr);
      budget--;
    end
    if (budget == 0) begin
      vecs++;
      miscmp++;
      $display("FAIL %s timeout: got %0d bytes expected %0d", name, out_q.size(), n_out);
    end
    repeat (3) step(1'b0, 1'b0);
  endtask

  task automatic add_frame(input logic [31:0] pw);
    logic [7:0] x = 8'h00;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(exp_seq);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b = pw[31-8*i -: 8];
      in_q.push_back(b);
      exp_q.push_back(b);
      x = x ^ b;
    end
`ifdef TX_FRAMER_CHECKSUM_EN
    exp_q.push_back(x);
`endif
    exp_seq = exp_seq + 8'h01;
  endtask

  task automatic compare_stream(input string name);
    int n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    check({name, "_len"}, out_q.size(), exp_q.size());
    for (int i = 0; i < n; i++) check({name, "_byte"}, out_q[i], exp_q[i]);
    out_q.delete();
    exp_q.delete();
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 8'hA5, 1'b0, 8'h00};
    tbl[2] = '{1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 8'h5A, 1'b0, 8'h00};
    tbl[3] = '{1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[4] = '{1'b1, 1'b1, 8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 8'h00};
    tbl[5] = '{1'b1, 1'b1, 8'h02, 1'b1, 1'b1, 8'h02, 1'b0, 8'h00};
    tbl[6] = '{1'b1, 1'b1, 8'h04, 1'b1, 1'b1, 8'h04, 1'b0, 8'h00};
    tbl[7] = '{1'b1, 1'b1, 8'h08, 1'b1, 1'b1, 8'h08, 1'b0, 8'h00};
`ifdef TX_FRAMER_CHECKSUM_EN
    tbl[8]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h0F, 1'b0, 8'h00};
    tbl[9]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h01};
    tbl[10] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h01};
`else
    tbl[8] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h01};
    tbl[9] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h01};
`endif

    reset_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    data_i  = 8'h00;
    @(negedge clk_i);
    do_reset();

    for (int i = 0; i < n_rows; i++) begin
      valid_i = tbl[i].vi;
      ready_i = tbl[i].ri;
      data_i  = tbl[i].di;
      #2;
      check($sformatf("tbl%0d_valid_o", i), valid_o, tbl[i].evo);
      check($sformatf("tbl%0d_ready_o", i), ready_o, tbl[i].ero);
      check($sformatf("tbl%0d_data_o", i), data_o, tbl[i].edo);
      check($sformatf("tbl%0d_done", i), frame_done_o, tbl[i].edone);
      check($sformatf("tbl%0d_seq", i), seq_o, tbl[i].eseq);
      @(posedge clk_i);
      @(negedge clk_i);
    end
    valid_i = 1'b0;

    do_reset();
    done_cnt = 0;
    add_frame(32'h11223344);
    add_frame(32'hDEADBEEF);
    add_frame(32'h00FF8001);
    run(exp_q.size(), 1'b0, 1'b0, "b2b");
    compare_stream("b2b");
    check("b2b_done_cnt", done_cnt, 3);
    check("b2b_seq_o", seq_o, 3);

    done_cnt = 0;
    add_frame(32'hC3A5F00F);
    add_frame(32'h12345678);
    run(exp_q.size(), 1'b1, 1'b0, "stall");
    compare_stream("stall");
    check("stall_done_cnt", done_cnt, 2);

    done_cnt = 0;
    add_frame(32'h01020408);
    add_frame(32'h80402010);
    run(exp_q.size(), 1'b1, 1'b1, "gap");
    compare_stream("gap");
    check("gap_done_cnt", done_cnt, 2);

    add_frame(32'hAABBCCDD);
    for (int b = 0; b < 200 && out_q.size() < 5; b++) step(1'b0, 1'b0);
    check("abort_bytes_out", out_q.size(), 5);
    do_reset();
    out_q.delete();
    exp_q.delete();
    done_cnt = 0;
    add_frame(32'h55667788);
    run(exp_q.size(), 1'b0, 1'b0, "after_abort");
    compare_stream("after_abort");
    check("after_abort_done", done_cnt, 1);

    done_cnt = 0;
    for (int f = 0; f < 256; f++) add_frame(32'($urandom));
    run(exp_q.size(), 1'b0, 1'b0, "wrap");
    check("wrap_seq_ff", out_q[254*flen+2], 8'hFF);
    check("wrap_seq_00", out_q[255*flen+2], 8'h00);
    compare_stream("wrap");
    check("wrap_done_cnt", done_cnt, 256);
    check("wrap_seq_o", seq_o, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule
